mb32_share_arbiter: RTL
=======================

// Module: mb32_share_arbiter
// PURPOSE
//  Shares one pipelined mb32_top Booth multiplier (mx/my in, product out,
//  fixed latency, no stall) between NREQ requesters.
//  - Round-robin grant of one request per cycle into the multiplier.
//  - Tags each issued operation with its requester id.
//  - Returns each product with that id after the fixed pipeline latency.
//  - A pause/drain FSM quiesces the multiplier for reconfiguration or test.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH
//  NREQ   4   number of requesters (2..8)
//  LAT    3   cycles from mx/my register update to matching product (>=1)
//  IDW    2   requester id width, >= clog2(NREQ)
// PORTS
//  CLK          in   1            clock, all logic on posedge
//  RST          in   1            synchronous reset, active-low
//  req_valid    in   NREQ         request i valid
//  req_x        in   NREQ*WIDTH   operand x of req i, bits [i*WIDTH +: WIDTH]
//  req_y        in   NREQ*WIDTH   operand y of req i, same packing
//  req_ready    out  NREQ         one-hot grant; handshake = valid&ready
//  mx           out  WIDTH        registered operand x to multiplier
//  my           out  WIDTH        registered operand y to multiplier
//  product      in   2*WIDTH      multiplier result
//  rsp_valid    out  1            response valid (no backpressure)
//  rsp_id       out  IDW          requester id of response
//  rsp_product  out  2*WIDTH      response product (= product input)
//  pause_req    in   1            request to stop issuing and drain
//  paused       out  1            pipeline empty, no issue in progress
//  busy         out  1            at least one op in flight
// BEHAVIOUR
//  Reset (RST=0 at posedge): mx=my=0, valid/id pipe cleared, rr pointer=0,
//   state=RUN, rsp_valid=0, rsp_id=0, paused=0, busy=0.
//  Arbitration: combinational, in state RUN only.
//   - Grant the first valid i searching from rr pointer upward, modulo NREQ.
//   - req_ready is one-hot or zero; requesters may keep valid high across cycles.
//  Issue: on handshake at posedge k, mx/my <= req_x/req_y[i]; vpipe[0]<=1,
//   idpipe[0]<=i; rr <= (i+1)%NREQ. No handshake: vpipe[0]<=0, mx/my hold.
//  Pipe: vpipe/idpipe shift every cycle, length LAT.
//   rsp_valid=vpipe[LAT-1], rsp_id=idpipe[LAT-1], rsp_product=product
//   (comb). An op issued at edge k responds in cycle after edge k+LAT-1.
//  Throughput: one op per cycle; back-to-back responses allowed.
//  busy = OR of vpipe.
//  FSM states:
//   RUN    - issue enabled. pause_req=1 -> DRAIN (no grant that cycle).
//   DRAIN  - no grants, wait for busy=0 -> PAUSED; pause_req=0 -> RUN.
//   PAUSED - paused=1, no grants; pause_req=0 -> RUN next cycle.
//  Boundaries:
//   - No requests: rr holds, vpipe fills with 0.
//   - rr wraps NREQ-1 -> 0.
//   - pause_req rising in the same cycle as a valid request: that request is NOT
//     granted.
//   - Reset mid-operation discards all in-flight ops; no response emitted.
//  Width: product is 2*WIDTH unsigned; the arbiter never modifies data.
// CONFIGURATION
//  MB32_ARB_PERF_EN defined:
//   - Adds output grant_cnt [NREQ*16-1:0], a 16-bit per-requester grant counter.
//   - Counters saturate at 16'hFFFF and reset to 0 on RST.
//   - Counters also clear on a posedge with paused=1 and pause_req=0.
//  MB32_ARB_PERF_EN undefined: no counters, no grant_cnt port.
// TESTING
//  1 single: req0 x=3 y=5 once -> after LAT cycles rsp_valid=1,
//    rsp_id=0, rsp_product=15.
//  2 fairness: all 4 valid constantly for 8 cycles -> grant order
//    0,1,2,3,0,1,2,3; responses in same order, 1 per cycle.
//  3 wrap/skip: rr=3, only req1,req2 valid -> grants 1,2,1,2.
//  4 max value: x=y=32'hFFFFFFFF -> rsp_product=64'hFFFFFFFE00000001.
//  5 pause: 3 ops in flight, pause_req=1 -> no grants, 3 responses drain,
//    paused=1 at cycle LAT+1; release -> grants resume next cycle.
//  6 reset mid-flight: RST=0 with 2 ops in flight -> rsp_valid stays 0,
//    mx=my=0, rr=0; with PERF_EN, grant_cnt=0.

Source files
------------

// File: rtl/mb32_share_arbiter.sv
// rtl/mb32_share_arbiter.sv - round-robin sharing of one pipelined multiplier among NREQ requesters; optional MB32_ARB_PERF_EN adds grant_cnt
module mb32_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int IDW   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      mx,
    output logic [WIDTH-1:0]      my,
    input  logic [2*WIDTH-1:0]    product,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_product,
    input  logic                  pause_req,
    output logic                  paused,
    output logic                  busy
`ifdef MB32_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]    grant_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_paused;
    logic [IDW-1:0]     r_rr;
    logic [WIDTH-1:0]   r_mx;
    logic [WIDTH-1:0]   r_my;
    logic [LAT-1:0]     r_vpipe;
    logic [IDW-1:0]     r_idpipe [LAT];

    logic               w_gnt;
    logic [NREQ-1:0]    w_ready;
    logic [IDW-1:0]     w_gnt_id;
    logic [WIDTH-1:0]   w_gx;
    logic [WIDTH-1:0]   w_gy;
    logic [IDW-1:0]     w_rr_next;
    logic               w_busy;

    // Round-robin search from the pointer; a pause request blocks the grant in the same cycle
    always_comb begin
        int idx;
        idx      = 0;
        w_gnt    = 1'b0;
        w_ready  = '0;
        w_gnt_id = '0;
        w_gx     = '0;
        w_gy     = '0;
        if (r_state == ST_RUN && !pause_req) begin
            for (int j = 0; j < NREQ; j++) begin
                idx = int'(r_rr) + j;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!w_gnt && req_valid[idx]) begin
                    w_gnt        = 1'b1;
                    w_ready[idx] = 1'b1;
                    w_gnt_id     = IDW'(idx);
                    w_gx         = req_x[idx*WIDTH +: WIDTH];
                    w_gy         = req_y[idx*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign w_rr_next = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;
    assign w_busy    = |r_vpipe;

    // Operand registers, rr pointer and the valid/id tag pipe that tracks the multiplier
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_mx    <= '0;
            r_my    <= '0;
            r_rr    <= '0;
            r_vpipe <= '0;
            for (int i = 0; i < LAT; i++) r_idpipe[i] <= '0;
        end else begin
            for (int i = LAT-1; i > 0; i--) begin
                r_vpipe[i]  <= r_vpipe[i-1];
                r_idpipe[i] <= r_idpipe[i-1];
            end
            r_vpipe[0] <= w_gnt;
            if (w_gnt) begin
                r_mx        <= w_gx;
                r_my        <= w_gy;
                r_idpipe[0] <= w_gnt_id;
                r_rr        <= w_rr_next;
            end
        end
    end

    // Pause/drain FSM: stop issuing, wait for the pipe to empty, then report paused
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= ST_RUN;
            r_paused <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (pause_req) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!pause_req) begin
                        r_state <= ST_RUN;
                    end else if (!w_busy) begin
                        r_state  <= ST_PAUSED;
                        r_paused <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!pause_req) begin
                        r_state  <= ST_RUN;
                        r_paused <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_paused <= 1'b0;
                end
            endcase
        end
    end

`ifdef MB32_ARB_PERF_EN
    logic [NREQ*16-1:0] r_grant_cnt;

    // Saturating per-requester grant counters, cleared when leaving the paused state
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_grant_cnt <= '0;
        end else if (r_paused && !pause_req) begin
            r_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_ready[i] && r_grant_cnt[i*16 +: 16] != 16'hFFFF)
                    r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

    assign req_ready   = w_ready;
    assign mx          = r_mx;
    assign my          = r_my;
    assign rsp_valid   = r_vpipe[LAT-1];
    assign rsp_id      = r_idpipe[LAT-1];
    assign rsp_product = product;
    assign paused      = r_paused;
    assign busy        = w_busy;

endmodule
